// File: rtl/clk_div_pkg.sv
// Shared definitions for the clock divider: default ratio width, FSM encoding, minimum divide ratio.
// Latency: n/a (definitions only). Backpressure: n/a.
package clk_div_pkg;

  localparam int RATIO_WIDTH_DEF = 8;
  localparam int MIN_DIV_RATIO   = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/clk_bypass_mux.sv
// Selects between the reference clock (bypass) and the divided clock; stand-in for a library glitch-free clock mux.
// Latency: combinational. Backpressure: none.
module clk_bypass_mux (
  input  logic i_clk,
  input  logic i_div_clk,
  input  logic i_sel,
  output logic o_clk
);

  assign o_clk = i_sel ? i_div_clk : i_clk;

endmodule

// File: rtl/clk_div.sv
// Integer clock divider: ceil(N/2) low / floor(N/2) high per N-cycle period, bypass when disabled or N<2.
// Latency: new ratio/enable take effect at the next period boundary. Backpressure: none.
module clk_div
  import clk_div_pkg::*;
#(
  parameter int RATIO_WIDTH = RATIO_WIDTH_DEF
) (
  input  logic                   i_ref_clk,
  input  logic                   i_rst_n,
  input  logic                   i_clk_en,
  input  logic [RATIO_WIDTH-1:0] i_div_ratio,
  output logic                   o_div_clk
);

  state_t                 r_state;
  logic [RATIO_WIDTH-1:0] r_cnt;
  logic [RATIO_WIDTH-1:0] r_ratio_q;
  logic                   r_div_q;

  state_t                 w_state_nxt;
  logic [RATIO_WIDTH-1:0] w_cnt_nxt;
  logic [RATIO_WIDTH-1:0] w_ratio_nxt;
  logic                   w_div_nxt;

  logic                   w_start;
  logic                   w_boundary;
  logic [RATIO_WIDTH-1:0] w_cnt_inc;
  logic [RATIO_WIDTH-1:0] w_half_lo;
  logic                   w_sel;

  assign w_start    = i_clk_en && (i_div_ratio >= RATIO_WIDTH'(MIN_DIV_RATIO));
  assign w_boundary = (r_cnt == (r_ratio_q - RATIO_WIDTH'(1)));
  assign w_cnt_inc  = r_cnt + RATIO_WIDTH'(1);
  // ceil(N/2) without widening: N>>1 plus the odd bit, so 255 gives 128.
  assign w_half_lo  = (r_ratio_q >> 1) + {{(RATIO_WIDTH-1){1'b0}}, r_ratio_q[0]};

  always_ff @(posedge i_ref_clk) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_ratio_q <= '0;
      r_div_q   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_ratio_q <= w_ratio_nxt;
      r_div_q   <= w_div_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ratio_nxt = r_ratio_q;
    w_div_nxt   = r_div_q;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_nxt = ST_RUN;
          w_ratio_nxt = i_div_ratio;
          w_cnt_nxt   = '0;
          w_div_nxt   = 1'b0;
        end
      end
      ST_RUN: begin
        if (w_boundary) begin
          w_cnt_nxt = '0;
          w_div_nxt = 1'b0;
          // Enable drop wins over any simultaneous ratio change.
          if (w_start) begin
            w_ratio_nxt = i_div_ratio;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_cnt_nxt = w_cnt_inc;
          w_div_nxt = (w_cnt_inc >= w_half_lo);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
        w_div_nxt   = 1'b0;
      end
    endcase
  end

  assign w_sel = (r_state == ST_RUN);

  clk_bypass_mux u_bypass_mux (
    .i_clk     (i_ref_clk),
    .i_div_clk (r_div_q),
    .i_sel     (w_sel),
    .o_clk     (o_div_clk)
  );

endmodule

// File: tb/tb_clk_div.sv
// Scoreboard bench for clk_div: a period-plan model queues the expected level of each ref cycle,
// and a monitor checks o_div_clk in both halves of every cycle.
module tb_clk_div;

  localparam int RW = 8;

  logic          ref_clk = 1'b0;
  logic          rst_n   = 1'b0;
  logic          clk_en  = 1'b0;
  logic [RW-1:0] div_ratio = '0;
  logic          div_clk;

  int checks   = 0;
  int failures = 0;

  // Expected per-cycle behaviour: 0 = low, 1 = high, 2 = follows ref clock.
  int exp_q[$];

  // Reference model state: bypass flag and remaining levels of the current period.
  bit model_bypass = 1'b1;
  int plan[$];

  clk_div #(.RATIO_WIDTH(RW)) dut (
    .i_ref_clk   (ref_clk),
    .i_rst_n     (rst_n),
    .i_clk_en    (clk_en),
    .i_div_ratio (div_ratio),
    .o_div_clk   (div_clk)
  );

  always #5 ref_clk = ~ref_clk;

  function automatic void load_period(int n);
    plan.delete();
    for (int i = 0; i < n; i++) plan.push_back((i < (n + 1) / 2) ? 0 : 1);
  endfunction

  always @(posedge ref_clk) begin
    int n;
    n = int'(div_ratio);
    if (!rst_n) begin
      model_bypass = 1'b1;
      plan.delete();
    end else if (model_bypass) begin
      if (clk_en && n >= 2) begin
        model_bypass = 1'b0;
        load_period(n);
      end
    end else if (plan.size() == 0) begin
      if (clk_en && n >= 2) load_period(n);
      else model_bypass = 1'b1;
    end
    if (model_bypass) exp_q.push_back(2);
    else exp_q.push_back(plan.pop_front());
  end

  // Monitor: high-phase sample 2ns after the rising edge, low-phase sample 2ns after the falling edge.
  initial begin
    int e;
    logic want;
    forever begin
      @(posedge ref_clk);
      #2;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_empty t=%0t: no expected entry for this cycle", $time);
        e = 2;
      end else begin
        e = exp_q.pop_front();
      end
      want = (e == 2) ? 1'b1 : e[0];
      checks++;
      if (div_clk !== want) begin
        failures++;
        $display("FAIL div_clk_high_phase t=%0t: got %b expected %b", $time, div_clk, want);
      end
      @(negedge ref_clk);
      #2;
      want = (e == 2) ? 1'b0 : e[0];
      checks++;
      if (div_clk !== want) begin
        failures++;
        $display("FAIL div_clk_low_phase t=%0t: got %b expected %b", $time, div_clk, want);
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge ref_clk);
  endtask

  task automatic drive(bit en, int ratio, int n);
    clk_en    = en;
    div_ratio = RW'(ratio);
    cyc(n);
  endtask

  initial begin
    int r;
    rst_n = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(3);

    // Ratio 4 over more than ten periods.
    drive(1, 4, 46);

    // Ratio 5, then switch to 8 mid-period.
    drive(1, 5, 8);
    drive(1, 8, 34);

    // Ratios 0 and 1 bypass, 2 divides.
    drive(1, 0, 12);
    drive(1, 1, 10);
    drive(1, 2, 12);

    // Ratio 6 with enable dropped mid-period, then re-enabled.
    drive(1, 6, 9);
    drive(0, 6, 10);
    drive(1, 6, 20);

    // Ratio 7 with a one-cycle reset mid-period, enable held.
    drive(1, 7, 12);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    cyc(20);

    // Simultaneous ratio change and enable drop.
    drive(1, 3, 5);
    drive(0, 9, 10);

    // Largest ratio.
    drive(1, 255, 600);

    // Randomised enable/ratio/reset mix.
    for (int k = 0; k < 250; k++) begin
      case ($urandom_range(0, 5))
        0: r = 0;
        1: r = 1;
        2: r = 2;
        3: r = 3;
        default: r = $urandom_range(0, 20);
      endcase
      clk_en    = ($urandom_range(0, 4) != 0);
      div_ratio = RW'(r);
      rst_n     = ($urandom_range(0, 39) != 0);
      cyc(1);
      rst_n = 1'b1;
      cyc($urandom_range(0, 14));
    end

    drive(0, 0, 4);
    @(posedge ref_clk);
    #8;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
